// File: rtl/crcu_reg_pkg.sv
// Shared constants, APB state encoding and write-command payload for the CRCU reset-control register block.
package crcu_reg_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OFF_W   = 5;
    localparam int unsigned STATE_W = 2;

    localparam logic [OFF_W-1:0] OFF_CPM_CTL  = 5'h00;
    localparam logic [OFF_W-1:0] OFF_PERI_CTL = 5'h04;
    localparam logic [OFF_W-1:0] OFF_SWRST    = 5'h08;
    localparam logic [OFF_W-1:0] OFF_STATUS   = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_LOCK     = 5'h10;

    localparam logic [DATA_W-1:0] CTL_WMASK = 32'h0000_FF07;
    localparam logic [7:0]        LOCK_KEY  = 8'hA5;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_SETUP  = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACCESS = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        APB_IDLE   = ST_IDLE,
        APB_SETUP  = ST_SETUP,
        APB_ACCESS = ST_ACCESS
    } apb_state_t;

    // Write decoded in SETUP, committed on the edge that ends ACCESS.
    typedef struct packed {
        logic              wr_cpm;
        logic              wr_peri;
        logic              swrst;
        logic [DATA_W-1:0] wdata;
    } reg_cmd_t;

endpackage

// File: rtl/crcu_rst_apb_regs_if.sv
// APB3 bus bundle between the system bus master and the CRCU register slave.
interface crcu_rst_apb_regs_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/crcu_swrst_pulse.sv
// Self-timed software reset request: a start while idle yields a pulse SWRST_CYCLES clocks wide.
module crcu_swrst_pulse #(
    parameter int unsigned SWRST_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic sw_rst_req_o
);
    localparam int unsigned       CNT_W = 8;
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(SWRST_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;

    // Start is ignored while busy so a running pulse is never extended.
    always_comb begin
        cnt_d = cnt_q;
        req_d = req_q;
        if (start_i && !req_q) begin
            cnt_d = LOAD;
            req_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            req_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign busy_o       = req_q;
    assign sw_rst_req_o = req_q;

endmodule

// File: rtl/crcu_rst_apb_regs.sv
// APB3 slave holding the CRCU CPM/peripheral reset-control words and the software reset pulse.
// Optional write-once LOCK register enabled by defining CRCU_REG_LOCK_EN.
module crcu_rst_apb_regs
    import crcu_reg_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned SWRST_CYCLES = 16
) (
    input  logic                  CRCU_CLK,
    input  logic                  CRCU_RST,
    crcu_rst_apb_regs_if.slave    apb,
    output logic [DATA_W-1:0]     cpm_rst_ctl_reg,
    output logic [DATA_W-1:0]     peri_rst_ctl_reg,
    output logic                  sw_rst_req
);
    apb_state_t        state_q, state_d;
    reg_cmd_t          cmd_q, cmd_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] cpm_q, peri_q;
    logic              swrst_busy;
    logic              locked_c;
    logic [ADDR_W-1:0] paddr_c;
    logic [OFF_W-1:0]  off_c;
    logic              unused_paddr;

    assign paddr_c      = apb.PADDR;
    assign off_c        = {paddr_c[4:2], 2'b00};
    assign unused_paddr = ^paddr_c;

`ifdef CRCU_REG_LOCK_EN
    logic lock_q, lock_wr_q, lock_wr_d;

    // Write-once lock; only reset clears it.
    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            lock_q    <= 1'b0;
            lock_wr_q <= 1'b0;
        end else begin
            lock_wr_q <= lock_wr_d;
            if (lock_wr_q) lock_q <= 1'b1;
        end
    end

    assign locked_c = lock_q;
`else
    assign locked_c = 1'b0;
`endif

    // Transfer FSM; decode happens in SETUP so ACCESS presents registered responses.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cmd_d.wr_cpm  = 1'b0;
        cmd_d.wr_peri = 1'b0;
        cmd_d.swrst   = 1'b0;
        pready_d      = 1'b0;
        pslverr_d     = 1'b0;
        prdata_d      = '0;
`ifdef CRCU_REG_LOCK_EN
        lock_wr_d     = 1'b0;
`endif
        case (state_q)
            APB_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) state_d = APB_SETUP;
            end
            APB_SETUP: begin
                if (!apb.PSEL) begin
                    state_d = APB_IDLE;
                end else begin
                    state_d     = APB_ACCESS;
                    pready_d    = 1'b1;
                    cmd_d.wdata = apb.PWDATA;
                    case (off_c)
                        OFF_CPM_CTL: begin
                            if (apb.PWRITE) begin
                                pslverr_d    = locked_c;
                                cmd_d.wr_cpm = !locked_c;
                            end else begin
                                prdata_d = cpm_q;
                            end
                        end
                        OFF_PERI_CTL: begin
                            if (apb.PWRITE) begin
                                pslverr_d     = locked_c;
                                cmd_d.wr_peri = !locked_c;
                            end else begin
                                prdata_d = peri_q;
                            end
                        end
                        OFF_SWRST: begin
                            if (apb.PWRITE) begin
                                pslverr_d   = locked_c;
                                cmd_d.swrst = !locked_c && apb.PWDATA[0];
                            end
                        end
                        OFF_STATUS: begin
                            if (apb.PWRITE) pslverr_d = 1'b1;
                            else            prdata_d  = {{(DATA_W-1){1'b0}}, swrst_busy};
                        end
`ifdef CRCU_REG_LOCK_EN
                        OFF_LOCK: begin
                            if (apb.PWRITE) lock_wr_d = (apb.PWDATA[7:0] == LOCK_KEY);
                            else            prdata_d  = {{(DATA_W-1){1'b0}}, lock_q};
                        end
`endif
                        default: pslverr_d = 1'b1;
                    endcase
                end
            end
            APB_ACCESS: begin
                if (apb.PSEL && !apb.PENABLE) state_d = APB_SETUP;
                else                          state_d = APB_IDLE;
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            state_q   <= APB_IDLE;
            cmd_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            cpm_q     <= '0;
            peri_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (cmd_q.wr_cpm)  cpm_q  <= cmd_q.wdata & CTL_WMASK;
            if (cmd_q.wr_peri) peri_q <= cmd_q.wdata & CTL_WMASK;
        end
    end

    crcu_swrst_pulse #(
        .SWRST_CYCLES (SWRST_CYCLES)
    ) u_swrst (
        .clk          (CRCU_CLK),
        .rst          (CRCU_RST),
        .start_i      (cmd_q.swrst),
        .busy_o       (swrst_busy),
        .sw_rst_req_o (sw_rst_req)
    );

    assign apb.PREADY       = pready_q;
    assign apb.PSLVERR      = pslverr_q;
    assign apb.PRDATA       = prdata_q;
    assign cpm_rst_ctl_reg  = cpm_q;
    assign peri_rst_ctl_reg = peri_q;

endmodule

// File: doc/crcu_rst_apb_regs.md
# crcu_rst_apb_regs

APB3 slave register block for the CRCU reset-control registers. It holds the `cpm_rst_ctl_reg` and `peri_rst_ctl_reg` control words that drive the per-domain reset generators downstream. It also produces a self-timed software reset request pulse. The block sits between the system APB bus and the reset generators, all on `CRCU_CLK`.

## Interface
Parameters:
- `ADDR_W`, default 8: APB address width. Only `PADDR[4:2]` is decoded; `PADDR[1:0]` is ignored.
- `SWRST_CYCLES`, default 16: width of the `sw_rst_req` pulse in `CRCU_CLK` cycles. Legal range is 1..255.

Ports:
- `CRCU_CLK`, in, 1: block clock.
- `CRCU_RST`, in, 1: reset; asynchronous, active-high.
- `PSEL`, in, 1: APB select.
- `PENABLE`, in, 1: APB enable.
- `PWRITE`, in, 1: 1 = write, 0 = read.
- `PADDR`, in, `ADDR_W`: byte address.
- `PWDATA`, in, 32: write data.
- `PRDATA`, out, 32: read data; valid when `PREADY` = 1.
- `PREADY`, out, 1: transfer complete.
- `PSLVERR`, out, 1: error response; valid only when `PREADY` = 1.
- `cpm_rst_ctl_reg`, out, 32: CPM reset control word.
- `peri_rst_ctl_reg`, out, 32: peripheral reset control word.
- `sw_rst_req`, out, 1: active-high software reset request pulse.

## Operation
Register map:
- `0x00 CPM_CTL`, RW. Bit 0 = enable, bit 1 = async, bit 2 = polarity, bits [15:8] = assert width. All other bits are read-only and read 0.
- `0x04 PERI_CTL`, RW. Same layout as `CPM_CTL`.
- `0x08 SWRST`, write-only. Writing bit 0 = 1 starts the pulse. Reads return 0.
- `0x0C STATUS`, RO. Bit 0 = swrst busy. Any write returns `PSLVERR`.
- `0x10 LOCK`: see Configuration.
- Any other decoded address returns `PSLVERR`, has no side effects, and reads 0.

APB state machine, with states IDLE, SETUP and ACCESS:
- IDLE → SETUP when `PSEL` = 1 and `PENABLE` = 0.
- SETUP → ACCESS on the next cycle. The block samples the address, data and direction and decodes them in this cycle.
- ACCESS: `PREADY` = 1 for exactly one cycle. The write commits on the same edge that ends ACCESS. `PRDATA` and `PSLVERR` are registered and valid throughout ACCESS.
- ACCESS → SETUP if `PSEL` = 1 and `PENABLE` = 0 (back-to-back transfer). Otherwise ACCESS → IDLE.
- `PSEL` dropping during SETUP aborts the transfer to IDLE with no write.

Software reset pulse:
- A write to `SWRST` with bit 0 = 1 while idle loads a counter with `SWRST_CYCLES`.
- `sw_rst_req` goes high on the cycle after ACCESS and stays high for exactly `SWRST_CYCLES` cycles.
- `STATUS[0]` = `sw_rst_req`.
- A `SWRST` write while busy is ignored and returns `PSLVERR` = 0. The pulse is not extended.
- A `SWRST` write with bit 0 = 0 is a no-op.

Control register writes:
- Writes are masked to bits [2:0] and [15:8].
- The outputs `cpm_rst_ctl_reg` and `peri_rst_ctl_reg` come directly from the storage flops.

## Timing
- Reset values:
  - `cpm_rst_ctl_reg` = 0, `peri_rst_ctl_reg` = 0, `sw_rst_req` = 0.
  - `PREADY` = 0, `PSLVERR` = 0, `PRDATA` = 0.
  - State = IDLE, counter = 0, lock = 0.
- Latency: every transfer takes 3 cycles from `PSEL` (SETUP, wait, ACCESS), i.e. one wait state.
- Control outputs update on the cycle after `PREADY`.
- `CRCU_RST` asserted mid-transfer or mid-pulse returns every flop to its reset value immediately. The write is lost and `sw_rst_req` drops asynchronously.
- A read of `STATUS` in the same ACCESS cycle that the pulse starts returns 0. The pulse starts on the following edge.
- A read of `STATUS` on the last pulse cycle returns 1.
- The counter is 8 bits wide and decrements to 0. It never wraps.

## Configuration
Macro `CRCU_REG_LOCK_EN`.

With the macro defined:
- `0x10 LOCK` is a write-once register. Writing `PWDATA[7:0]` = `0xA5` sets lock bit 0. Any other value is ignored.
- Once locked, writes to `CPM_CTL`, `PERI_CTL` and `SWRST` return `PSLVERR` = 1 and change nothing.
- The lock clears only on `CRCU_RST`. Reading `LOCK` returns the lock bit.

Without the macro:
- `0x10` is unmapped and returns `PSLVERR` = 1.
- No lock logic is present.

## Structure
- Package `crcu_reg_pkg` holds:
  - the address offset constants;
  - the write masks (`CTL_WMASK` = `32'h0000_FF07`);
  - the lock key `0xA5`;
  - the APB state enum `apb_state_t`.
- Sub-module `crcu_swrst_pulse` contains the counter and the busy/pulse generation. Its interface is start, busy, `sw_rst_req`, parameterised by `SWRST_CYCLES`.

## Test plan
- Reset, then read `0x00`, `0x04` and `0x0C` → `PRDATA` = 0, `PSLVERR` = 0, `PREADY` on the 3rd cycle of each transfer.
- Write `0xFFFF_FFFF` to `0x00`, then read it back → `cpm_rst_ctl_reg` = `0x0000_FF07` the cycle after `PREADY`, readback `0x0000_FF07`, `peri_rst_ctl_reg` unchanged at 0.
- `SWRST_CYCLES` = 16: write 1 to `0x08` → `sw_rst_req` high exactly 16 cycles. A second write at pulse cycle 5 → no extension and `PSLVERR` = 0. `STATUS` reads 1 during the pulse and 0 after.
- Write to `0x0C` and to `0x14` → `PSLVERR` = 1, no register change. A read of `0x14` returns 0 with `PSLVERR` = 1.
- Assert `CRCU_RST` during the ACCESS of a write of `0x5` to `0x04`, and at pulse cycle 3 → register stays 0 and `sw_rst_req` drops with no clock edge.
- With `CRCU_REG_LOCK_EN`: write `0x5A` to `0x10` → still unlocked. Write `0xA5` → `LOCK` reads 1. A write to `0x00` then returns `PSLVERR` = 1 and leaves the value unchanged.
